// File: rtl/cordic_polar_mc.sv
// Multi-channel iterative CORDIC vectoring engine: converts NCH (X, Y) pairs per
// sample strobe into a full-range atan2 angle (fixed-point degrees) and a magnitude.
module cordic_polar_mc #(
    parameter int IN_W     = 13,
    parameter int ANG_W    = 19,
    parameter int ANG_FRAC = 10,
    parameter int ITER     = 16,
    parameter int NCH      = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   endata,
    input  logic [NCH*IN_W-1:0]                    x_in,
    input  logic [NCH*IN_W-1:0]                    y_in,
    output logic signed [ANG_W-1:0]                angle,
    output logic [IN_W:0]                          mag,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic                                   out_valid,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IT_W   = $clog2(ITER);
    // Fraction bits below the integer datapath keep truncation error of the
    // micro-rotations well under one angle LSB even at small radii.
    localparam int GB     = 12;
    localparam int W      = IN_W + 2 + GB;
    localparam int ZW     = ANG_W + 1;
    localparam int K_FRAC = 18;
    localparam logic [K_FRAC-1:0]   K_MAG   = 18'd159189;  // 0.6072529 * 2^18
    localparam logic signed [ZW-1:0] Z_180  = ZW'(180 * (2 ** ANG_FRAC));
    localparam logic [W+K_FRAC-1:0] MAG_RND = (W+K_FRAC)'(1) << (GB + K_FRAC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_OUT} state_t;

    state_t state, next_state;

    logic [NCH*IN_W-1:0]   xs, ys;
    logic signed [W-1:0]   xr, yr;
    logic signed [ZW-1:0]  zr;
    logic [IT_W-1:0]       iter;
    logic [CH_W-1:0]       ch;
    logic                  axis, negx;

    logic                  do_load, do_rot, do_out, accept, reject;
    logic                  last_iter, last_ch;
    logic signed [IN_W-1:0] cx, cy;
    logic signed [W-1:0]   cx_ext, cy_ext, xsh, ysh;
    logic [W+K_FRAC-1:0]   prod;
    logic [W-1:0]          mag_q;
    logic [IN_W:0]         mag_sat;

    // atan(2^-i) in degrees scaled by 2^16, rounded to ANG_FRAC bits (ANG_FRAC <= 15).
    function automatic logic signed [ZW-1:0] atan_rom(input int i);
        logic [31:0] t16;
        case (i)
            0:  t16 = 32'd2949120;
            1:  t16 = 32'd1740967;
            2:  t16 = 32'd919879;
            3:  t16 = 32'd466945;
            4:  t16 = 32'd234379;
            5:  t16 = 32'd117304;
            6:  t16 = 32'd58666;
            7:  t16 = 32'd29335;
            8:  t16 = 32'd14668;
            9:  t16 = 32'd7334;
            10: t16 = 32'd3667;
            11: t16 = 32'd1833;
            12: t16 = 32'd917;
            13: t16 = 32'd458;
            14: t16 = 32'd229;
            15: t16 = 32'd115;
            16: t16 = 32'd57;
            17: t16 = 32'd29;
            18: t16 = 32'd14;
            19: t16 = 32'd7;
            default: t16 = 32'd0;
        endcase
        return ZW'((t16 + (32'd1 << (15 - ANG_FRAC))) >> (16 - ANG_FRAC));
    endfunction

    assign last_iter = (iter == IT_W'(ITER - 1));
    assign last_ch   = (ch == CH_W'(NCH - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (endata) next_state = S_LOAD;
            S_LOAD:  next_state = S_ROT;
            S_ROT:   if (last_iter) next_state = S_OUT;
            S_OUT:   next_state = last_ch ? S_IDLE : S_LOAD;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        accept  = 1'b0;
        do_load = 1'b0;
        do_rot  = 1'b0;
        do_out  = 1'b0;
        case (state)
            S_IDLE:  accept = endata;
            S_LOAD:  begin busy = 1'b1; do_load = 1'b1; end
            S_ROT:   begin busy = 1'b1; do_rot  = 1'b1; end
            S_OUT:   begin busy = 1'b1; do_out  = 1'b1; end
            default: busy = 1'b0;
        endcase
        reject = endata && busy;
    end

    assign cx     = xs[int'(ch)*IN_W +: IN_W];
    assign cy     = ys[int'(ch)*IN_W +: IN_W];
    assign cx_ext = {{2{cx[IN_W-1]}}, cx, {GB{1'b0}}};
    assign cy_ext = {{2{cy[IN_W-1]}}, cy, {GB{1'b0}}};
    assign xsh    = xr >>> iter;
    assign ysh    = yr >>> iter;

    always_comb begin
        prod    = xr[W-1] ? '0 : ({{K_FRAC{1'b0}}, xr} * {{W{1'b0}}, K_MAG});
        mag_q   = W'((prod + MAG_RND) >> (GB + K_FRAC));
        mag_sat = (|(mag_q >> (IN_W + 1))) ? {(IN_W+1){1'b1}} : mag_q[IN_W:0];
    end

    // NOTE: the frame sample registers are reset along with the datapath so an
    // aborted frame leaves nothing behind; this is cheap at NCH*2 words.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xs        <= '0;
            ys        <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            iter      <= '0;
            ch        <= '0;
            axis      <= 1'b0;
            negx      <= 1'b0;
            angle     <= '0;
            mag       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= do_out;
            overrun   <= reject;
            if (accept) begin
                xs <= x_in;
                ys <= y_in;
                ch <= '0;
            end
            if (do_load) begin
                iter <= '0;
                axis <= (cy == '0);
                negx <= cx[IN_W-1];
                if (cx[IN_W-1]) begin
                    xr <= -cx_ext;
                    yr <= -cy_ext;
                    zr <= cy[IN_W-1] ? -Z_180 : Z_180;
                end else begin
                    xr <= cx_ext;
                    yr <= cy_ext;
                    zr <= '0;
                end
            end
            if (do_rot) begin
                iter <= iter + IT_W'(1);
                if (!yr[W-1]) begin
                    xr <= xr + ysh;
                    yr <= yr - xsh;
                    zr <= zr + atan_rom(int'(iter));
                end else begin
                    xr <= xr - ysh;
                    yr <= yr + xsh;
                    zr <= zr - atan_rom(int'(iter));
                end
            end
            if (do_out) begin
                // On the X axis the angle is known exactly; bypass CORDIC residue.
                if (axis) angle <= negx ? ANG_W'(Z_180) : '0;
                else      angle <= ANG_W'(zr);
                mag    <= mag_sat;
                out_ch <= ch;
                if (!last_ch) ch <= ch + CH_W'(1);
            end
        end
    end

endmodule
